bit_serial_adder: RTL
=====================

// Module: bit_serial_adder
//
// PURPOSE
// Bit-serial ripple adder stage feeding the top-level I/O mapping. Consumes two
// operands LSB-first, one bit pair per accepted cycle, with a single stored carry.
// Assembles the WIDTH-bit sum in a shift register and presents it with carry-out
// under a valid/ready handshake for the pad-output stage to drive onto uo_out.
//
// PARAMETERS
// WIDTH  8  operand/sum width in bits (>=2); also the number of bit pairs per operation
//
// PORTS
// clk        in   1      single clock; all state updates on rising edge
// rst_n      in   1      synchronous active-low reset
// start      in   1      begin new operation; cin sampled same cycle
// cin        in   1      carry-in, sampled only when start is accepted
// in_valid   in   1      a_bit/b_bit valid this cycle
// a_bit      in   1      operand A bit, LSB first
// b_bit      in   1      operand B bit, LSB first
// in_ready   out  1      high while in RUN; bit pair accepted when in_valid & in_ready
// sum        out  WIDTH  result; meaningful only while out_valid=1
// cout       out  1      carry-out of MSB; meaningful only while out_valid=1
// out_valid  out  1      result available
// out_ready  in   1      consumer takes result when out_valid & out_ready
// busy       out  1      high in any state other than IDLE
//
// BEHAVIOUR
// - Reset (rst_n=0 at clk edge): state=IDLE, sum=0, cout=0, carry=0, bit count=0;
//   out_valid=0, in_ready=0, busy=0. Applies mid-operation: partial result discarded.
// - States: IDLE, RUN, HOLD. in_ready=(state==RUN); out_valid=(state==HOLD); busy=(state!=IDLE).
// - IDLE: start=1 -> carry<=cin, sum<=0, cnt<=0, state<=RUN. in_valid ignored.
// - RUN, accept (in_valid=1): s=a^b^carry; carry<=maj(a,b,carry);
//   sum<={s, sum[WIDTH-1:1]} (after WIDTH shifts the first bit sits at sum[0]); cnt<=cnt+1.
// - RUN, accept with cnt==WIDTH-1: additionally cout<=maj(a,b,carry), state<=HOLD.
// - RUN, in_valid=0: full stall, no state change. start ignored in RUN.
// - HOLD: sum and cout held stable. out_ready=1 -> state<=IDLE.
//   out_ready=1 & start=1 same cycle -> result transferred and new operation begins:
//   carry<=cin, sum<=0, cnt<=0, state<=RUN (back-to-back, no IDLE cycle).
//   start=1 with out_ready=0 ignored.
// - Latency: start at cycle 0 -> bit pairs accepted cycles 1..WIDTH (no stalls) ->
//   out_valid=1 at cycle WIDTH+1. Each stalled cycle adds one cycle.
// - Counter wraps never: cnt width = clog2(WIDTH), cleared on start; terminal at WIDTH-1.
// - sum is modulo 2^WIDTH; true result is {cout,sum}.
// - cout keeps last value outside HOLD; sum reads 0 / partial during RUN (not valid).
//
// TESTING
// 1. rst_n=0 for 3 cycles while start/in_valid toggle -> all outputs 0, state IDLE.
// 2. cin=0, A=8'h5A, B=8'h3C, no stalls -> out_valid at cycle 9, sum=8'h96, cout=0.
// 3. A=8'hFF,B=8'h01,cin=0 -> sum=8'h00,cout=1; A=8'hFF,B=8'h00,cin=1 -> sum=8'h00,cout=1.
// 4. A=8'h12,B=8'h34 with in_valid low 3 cycles after bit 3 -> sum=8'h46, out_valid at cycle 12.
// 5. out_ready=0 for 5 cycles in HOLD -> sum/cout stable, in_ready=0; then out_ready=1 &
//    start=1 -> RUN next cycle, out_valid=0, next op A=8'h01,B=8'h01 -> sum=8'h02.
// 6. rst_n=0 after 4 bits accepted -> outputs 0 next edge; following op 8'h80+8'h80 -> sum=0, cout=1.

Source files
------------

// File: rtl/bit_serial_adder.sv
// Bit-serial ripple adder: accepts operand bit pairs LSB-first under a valid/ready
// handshake, keeps one carry, and presents {cout,sum} for the output stage.
module bit_serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             cin,
   input  logic             in_valid,
   input  logic             a_bit,
   input  logic             b_bit,
   output logic             in_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      HOLD
   } state_t;

   state_t        state;
   logic          carry;
   logic [CW-1:0] cnt;
   logic          s_bit;
   logic          c_next;

   always_comb begin
      s_bit  = a_bit ^ b_bit ^ carry;
      c_next = (a_bit & b_bit) | (a_bit & carry) | (b_bit & carry);
   end

   // Handshake flags are registered next to the state so they change on the same edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         sum       <= '0;
         cout      <= 1'b0;
         carry     <= 1'b0;
         cnt       <= '0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  carry    <= cin;
                  sum      <= '0;
                  cnt      <= '0;
                  state    <= RUN;
                  in_ready <= 1'b1;
                  busy     <= 1'b1;
               end
            end
            RUN: begin
               if (in_valid) begin
                  carry <= c_next;
                  sum   <= {s_bit, sum[WIDTH-1:1]};
                  cnt   <= cnt + 1'b1;
                  if (cnt == LAST) begin
                     cout      <= c_next;
                     state     <= HOLD;
                     in_ready  <= 1'b0;
                     out_valid <= 1'b1;
                  end
               end
            end
            HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  if (start) begin
                     carry    <= cin;
                     sum      <= '0;
                     cnt      <= '0;
                     state    <= RUN;
                     in_ready <= 1'b1;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b0;
               out_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule
